// File: rtl/keypad_reader.sv
// 4x4 matrix keypad scanner and debouncer. Builds a decimal entry of up to five digits
// and exposes the committed value and a valid flag on a memorio-style read port.
module keypad_reader #(
    parameter int SCAN_DIV = 100000,
    parameter int DEBOUNCE = 20
) (
    input  logic        clk,
    input  logic        rst,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    input  logic        keycs,
    input  logic        keyread,
    input  logic        keyaddr,
    output logic [16:0] read_data,
    output logic [16:0] entry_value,
    output logic [3:0]  last_key
);
    // state      | meaning
    // S_SCAN     | walking the rows, waiting for any low column
    // S_DEBOUNCE | row held, counting stable samples of the latched column pattern
    // S_PRESSED  | key accepted; its action fires on the first clk, then wait for release
    // S_RELEASE  | counting stable all-high samples before the scan resumes
    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

    localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam int               DB_W     = $clog2(DEBOUNCE + 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);

    logic [3:0]       col_meta, col_sync;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    state_t           state, state_nxt;
    logic [1:0]       row_idx, row_idx_nxt;
    logic [3:0]       pat, pat_nxt;
    logic [DB_W-1:0]  db_cnt, db_cnt_nxt;
    logic             act_pend, act_pend_nxt;
    logic [1:0]       col_idx;
    logic             is_digit, is_star, is_hash;
    logic [3:0]       digit;
    logic [16:0]      entry, value;
    logic [2:0]       count;
    logic             valid;
    logic             commit, rd_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta <= 4'hF;
            col_sync <= 4'hF;
        end else begin
            col_meta <= col;
            col_sync <= col_meta;
        end
    end

    assign tick = (div_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       div_cnt <= '0;
        else if (tick) div_cnt <= DIV_LAST;
        else           div_cnt <= div_cnt - DIV_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_SCAN;
            row_idx  <= 2'd0;
            pat      <= 4'hF;
            db_cnt   <= '0;
            act_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            row_idx  <= row_idx_nxt;
            pat      <= pat_nxt;
            db_cnt   <= db_cnt_nxt;
            act_pend <= act_pend_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        row_idx_nxt  = row_idx;
        pat_nxt      = pat;
        db_cnt_nxt   = db_cnt;
        act_pend_nxt = 1'b0;
        if (tick) begin
            case (state)
                S_SCAN: begin
                    if (col_sync != 4'hF) begin
                        pat_nxt    = col_sync;
                        db_cnt_nxt = DB_W'(1);
                        state_nxt  = S_DEBOUNCE;
                    end else begin
                        row_idx_nxt = row_idx + 2'd1;
                    end
                end
                S_DEBOUNCE: begin
                    if (col_sync == pat) begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                        if (db_cnt == DB_LAST) begin
                            state_nxt    = S_PRESSED;
                            act_pend_nxt = 1'b1;
                        end
                    end else begin
                        state_nxt = S_SCAN;
                    end
                end
                S_PRESSED: begin
                    if (col_sync == 4'hF) begin
                        db_cnt_nxt = DB_W'(1);
                        state_nxt  = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (col_sync == 4'hF) begin
                        db_cnt_nxt = db_cnt + DB_W'(1);
                        if (db_cnt == DB_LAST) begin
                            state_nxt   = S_SCAN;
                            row_idx_nxt = row_idx + 2'd1;
                        end
                    end else begin
                        state_nxt = S_PRESSED;
                    end
                end
                default: state_nxt = S_SCAN;
            endcase
        end
    end

    // Lowest low column wins when several keys of one row are down.
    always_comb begin
        casez (pat)
            4'b???0: col_idx = 2'd0;
            4'b??01: col_idx = 2'd1;
            4'b?011: col_idx = 2'd2;
            default: col_idx = 2'd3;
        endcase
    end

    always_comb begin
        is_digit = 1'b0;
        is_star  = 1'b0;
        is_hash  = 1'b0;
        digit    = 4'd0;
        if (col_idx != 2'd3) begin
            if (row_idx != 2'd3) begin
                is_digit = 1'b1;
                digit    = 4'(row_idx) * 4'd3 + 4'(col_idx) + 4'd1;
            end else begin
                is_digit = (col_idx == 2'd1);
                is_star  = (col_idx == 2'd0);
                is_hash  = (col_idx == 2'd2);
            end
        end
    end

    assign commit   = act_pend && is_hash;
    assign rd_value = keycs && keyread && !keyaddr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry    <= '0;
            count    <= '0;
            value    <= '0;
            valid    <= 1'b0;
            last_key <= 4'd0;
        end else begin
            if (act_pend) begin
                last_key <= {row_idx, col_idx};
                if (is_digit) begin
                    if (count < 3'd5) begin
                        entry <= entry * 17'd10 + 17'(digit);
                        count <= count + 3'd1;
                    end
                end else if (is_star || is_hash) begin
                    entry <= '0;
                    count <= '0;
                end
                if (is_hash) value <= entry;
            end
            // A commit on the same edge as a value read keeps valid set.
            if (commit)        valid <= 1'b1;
            else if (rd_value) valid <= 1'b0;
        end
    end

    always_comb begin
        read_data = '0;
        if (keycs && keyread) read_data = keyaddr ? {16'b0, valid} : value;
    end

    assign row         = ~(4'b0001 << row_idx);
    assign entry_value = entry;
endmodule

// File: tb/tb_keypad_reader.sv
// Bench for keypad_reader: a keypad model shorts the pressed key's column to its row,
// and a character-level model of the calculator-style entry predicts every observation.
module tb_keypad_reader;
    localparam int SCAN_DIV = 8;
    localparam int DEBOUNCE = 3;
    localparam int TICK     = SCAN_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row, col;
    logic        keycs, keyread, keyaddr;
    logic [16:0] read_data, entry_value;
    logic [3:0]  last_key;

    int n_cmp = 0;
    int n_bad = 0;

    logic       key_down;
    logic [1:0] key_row, key_col;
    logic [3:0] extra_cols;

    byte keymap [16] = '{"1","2","3","A","4","5","6","B","7","8","9","C","*","0","#","D"};
    logic [3:0] seq_a [4] = '{4'd0, 4'd1, 4'd2, 4'd14};
    logic [3:0] seq_b [6] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};

    int m_entry, m_count, m_value, m_valid, m_last;

    keypad_reader #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .keycs      (keycs),
        .keyread    (keyread),
        .keyaddr    (keyaddr),
        .read_data  (read_data),
        .entry_value(entry_value),
        .last_key   (last_key)
    );

    always #5 clk = ~clk;

    always_comb begin
        col = 4'hF;
        if (key_down && row[key_row] == 1'b0) col = ~(4'b0001 << key_col) & extra_cols;
    end

    function automatic void model_reset();
        m_entry = 0; m_count = 0; m_value = 0; m_valid = 0; m_last = 0;
    endfunction

    function automatic void model_key(input logic [3:0] code);
        byte ch;
        ch     = keymap[code];
        m_last = int'(code);
        if (ch >= "0" && ch <= "9") begin
            if (m_count < 5) begin
                m_entry = m_entry * 10 + int'(ch - "0");
                m_count++;
            end
        end else if (ch == "*") begin
            m_entry = 0; m_count = 0;
        end else if (ch == "#") begin
            m_value = m_entry; m_valid = 1; m_entry = 0; m_count = 0;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cpu_read(input logic addr, output logic [16:0] data);
        @(negedge clk);
        keycs = 1'b1; keyread = 1'b1; keyaddr = addr;
        #1 data = read_data;
        @(posedge clk);
        #1;
        keycs = 1'b0; keyread = 1'b0; keyaddr = 1'b0;
    endtask

    task automatic tap_key(input logic [3:0] code, input int hold_ticks);
        @(negedge clk);
        key_row = code[3:2]; key_col = code[1:0]; key_down = 1'b1;
        repeat (hold_ticks * TICK) @(negedge clk);
        key_down = 1'b0;
        repeat (8 * TICK) @(negedge clk);
    endtask

    task automatic tap_and_check(input logic [3:0] code);
        tap_key(code, 12);
        model_key(code);
        check("entry", 32'(entry_value), m_entry);
        check("last_key", 32'(last_key), m_last);
    endtask

    // Waits for the row drive to switch onto target, so the caller knows where the tick falls.
    task automatic wait_row(input logic [3:0] target, output bit ok);
        logic [3:0] prev;
        ok   = 1'b0;
        prev = row;
        for (int i = 0; i < 8 * TICK; i++) begin
            @(negedge clk);
            if (row == target && prev != target) begin
                ok = 1'b1;
                break;
            end
            prev = row;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] rd;
        logic [16:0] prev_rd;
        logic [3:0]  code;
        bit          ok;
        int          old_value;

        rst = 1'b1; key_down = 1'b0; key_row = 2'd0; key_col = 2'd0; extra_cols = 4'hF;
        keycs = 1'b0; keyread = 1'b0; keyaddr = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_row", 32'(row), 32'(4'b1110));
        check("rst_read_idle", 32'(read_data), 0);
        check("rst_entry", 32'(entry_value), 0);
        check("rst_last_key", 32'(last_key), 0);
        rst = 1'b0;
        cpu_read(1'b1, rd);
        check("rst_valid", 32'(rd), 0);

        // 1, 2, 3, # then read back the commit
        for (int i = 0; i < 4; i++) tap_and_check(seq_a[i]);
        @(negedge clk);
        keycs = 1'b0; keyread = 1'b1; keyaddr = 1'b1;
        #1 check("bus_idle_no_cs", 32'(read_data), 0);
        keyread = 1'b0;
        cpu_read(1'b1, rd);
        check("valid_after_commit", 32'(rd), m_valid);
        cpu_read(1'b0, rd);
        check("value_123", 32'(rd), m_value);
        m_valid = 0;
        cpu_read(1'b1, rd);
        check("valid_cleared", 32'(rd), m_valid);

        // '5' held for only two scan samples
        wait_row(4'b1101, ok);
        check("short_row_found", 32'(ok), 1);
        key_row = 2'd1; key_col = 2'd1; key_down = 1'b1;
        repeat (20) @(negedge clk);
        key_down = 1'b0;
        wait_row(4'b1011, ok);
        check("short_scan_resumed", 32'(ok), 1);
        check("short_entry", 32'(entry_value), m_entry);
        check("short_last_key", 32'(last_key), m_last);

        // six digits; the sixth is dropped, then '*' clears
        for (int i = 0; i < 6; i++) tap_and_check(seq_b[i]);
        tap_and_check(4'd12);

        // random keys against the model, then commit and read back
        for (int i = 0; i < 14; i++) begin
            code = 4'($urandom_range(0, 15));
            tap_and_check(code);
        end
        tap_and_check(4'd14);
        cpu_read(1'b0, rd);
        check("random_value", 32'(rd), m_value);
        m_valid = 0;

        // '3' and '2' together on row 0: the lower column ('2') is taken
        tap_and_check(4'd12);
        extra_cols = 4'b1101;
        tap_key(4'd2, 12);
        extra_cols = 4'hF;
        model_key(4'd1);
        check("multi_entry", 32'(entry_value), m_entry);
        check("multi_last_key", 32'(last_key), m_last);

        // long hold of '7' with release bounces: exactly one digit
        tap_and_check(4'd12);
        @(negedge clk);
        key_row = 2'd2; key_col = 2'd0; key_down = 1'b1;
        repeat (50 * TICK) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            key_down = 1'b0;
            repeat (TICK) @(negedge clk);
            key_down = 1'b1;
            repeat (TICK) @(negedge clk);
        end
        key_down = 1'b0;
        repeat (8 * TICK) @(negedge clk);
        model_key(4'd8);
        check("hold7_entry", 32'(entry_value), m_entry);
        check("hold7_last_key", 32'(last_key), m_last);

        // commit landing on the same edge as a value read
        tap_and_check(4'd12);
        tap_and_check(4'd4);
        tap_and_check(4'd1);
        old_value = m_value;
        @(negedge clk);
        key_row = 2'd3; key_col = 2'd2; key_down = 1'b1;
        keycs = 1'b1; keyread = 1'b1; keyaddr = 1'b0;
        ok = 1'b0;
        prev_rd = '0;
        for (int i = 0; i < 20 * TICK; i++) begin
            #1 prev_rd = read_data;
            @(negedge clk);
            if (entry_value == 17'd0) begin
                ok = 1'b1;
                break;
            end
        end
        keycs = 1'b0; keyread = 1'b0;
        check("same_edge_commit_seen", 32'(ok), 1);
        check("same_edge_old_value", 32'(prev_rd), old_value);
        model_key(4'd14);
        cpu_read(1'b1, rd);
        check("same_edge_valid_set", 32'(rd), m_valid);
        key_down = 1'b0;
        repeat (8 * TICK) @(negedge clk);
        cpu_read(1'b0, rd);
        check("same_edge_new_value", 32'(rd), m_value);
        m_valid = 0;

        // reset while a key is being debounced
        tap_and_check(4'd10);
        tap_and_check(4'd14);
        tap_and_check(4'd5);
        wait_row(4'b1101, ok);
        check("dbrst_row_found", 32'(ok), 1);
        key_row = 2'd1; key_col = 2'd2; key_down = 1'b1;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("dbrst_row", 32'(row), 32'(4'b1110));
        check("dbrst_entry", 32'(entry_value), m_entry);
        check("dbrst_last_key", 32'(last_key), m_last);
        keycs = 1'b1; keyread = 1'b1; keyaddr = 1'b0;
        #1 check("dbrst_value", 32'(read_data), m_value);
        keyaddr = 1'b1;
        #1 check("dbrst_valid", 32'(read_data), m_valid);
        keycs = 1'b0; keyread = 1'b0; keyaddr = 1'b0;
        repeat (3) @(negedge clk);
        key_down = 1'b0;
        rst = 1'b0;
        tap_and_check(4'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
